vmu_mem_resp: RTL

Memory-side responder for VMU load/store requests. It accepts byte addresses of the form scalar_base + (cnt << OFF_BITS) from the VMU address path and range/alignment-checks them. Good requests are converted to a row index into the vector scratchpad SRAM. Load data returns to the lanes in request order through a credit-protected response FIFO with valid/ready backpressure.

---
 rtl/vmu_pkg.sv | 27 ++
 rtl/vmu_mem_resp_if.sv | 44 ++++
 rtl/vmu_rsp_fifo.sv | 46 ++++
 rtl/vmu_mem_resp.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vmu_pkg.sv
// Shared geometry helpers and tag type for the VMU memory responder.
package vmu_pkg;

  localparam int SCALAR_W_DEF  = 32;
  localparam int NUM_LANE_DEF  = 8;
  localparam int LANE_DW_DEF   = 64;
  localparam int MEM_DEPTH_DEF = 1024;

  function automatic int calc_row_w(input int num_lane, input int lane_dw);
    return num_lane * lane_dw;
  endfunction

  // Byte offset bits within one SRAM row: lane select plus byte-in-lane.
  function automatic int calc_off_bits(input int num_lane, input int lane_dw);
    return $clog2(num_lane) + $clog2(lane_dw / 8);
  endfunction

  localparam int ROW_W    = calc_row_w(NUM_LANE_DEF, LANE_DW_DEF);
  localparam int OFF_BITS = calc_off_bits(NUM_LANE_DEF, LANE_DW_DEF);
  localparam int AW       = $clog2(MEM_DEPTH_DEF);

  typedef struct packed {
    logic vld;
    logic err;
  } tag_t;

endpackage

// File: rtl/vmu_mem_resp_if.sv
// Request, SRAM and response signal bundle of the VMU memory responder.
interface vmu_mem_resp_if
  import vmu_pkg::*;
#(
  parameter int ADDR_W = SCALAR_W_DEF,
  parameter int DATA_W = ROW_W,
  parameter int IDX_W  = AW
);

  logic              i_req_vld;
  logic              o_req_rdy;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;

  logic              o_mem_ce;
  logic              o_mem_we;
  logic [IDX_W-1:0]  o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_rsp_vld;
  logic              i_rsp_rdy;
  logic [DATA_W-1:0] o_rsp_data;
  logic              o_rsp_err;

  logic              o_store_err;
  logic              o_busy;

  modport slave (
    input  i_req_vld, i_req_we, i_req_addr, i_req_wdata,
    input  i_mem_rdata, i_rsp_rdy,
    output o_req_rdy, o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_rsp_vld, o_rsp_data, o_rsp_err, o_store_err, o_busy
  );

  modport master (
    output i_req_vld, i_req_we, i_req_addr, i_req_wdata,
    output i_mem_rdata, i_rsp_rdy,
    input  o_req_rdy, o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_rsp_vld, o_rsp_data, o_rsp_err, o_store_err, o_busy
  );

endinterface

// File: rtl/vmu_rsp_fifo.sv
// Flop-based synchronous FIFO holding load responses {data, err}.
module vmu_rsp_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/vmu_mem_resp.sv
// VMU memory-side responder: checks request addresses, drives the scratchpad
// SRAM and returns load data in order through a credit-protected FIFO.
module vmu_mem_resp
  import vmu_pkg::*;
#(
  parameter int SCALAR_WIDTH    = SCALAR_W_DEF,
  parameter int NUM_LANE        = NUM_LANE_DEF,
  parameter int LANE_DATA_WIDTH = LANE_DW_DEF,
  parameter int MEM_DEPTH       = MEM_DEPTH_DEF,
  parameter int RD_LAT          = 2,
  parameter int RSP_DEPTH       = 4
) (
  input  logic          clk,
  input  logic          rst,
  vmu_mem_resp_if.slave bus
);

  localparam int RW  = calc_row_w(NUM_LANE, LANE_DATA_WIDTH);
  localparam int OB  = calc_off_bits(NUM_LANE, LANE_DATA_WIDTH);
  localparam int MAW = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH + 1);

  logic [SCALAR_WIDTH-1:0] row_full;
  logic [MAW-1:0]          row;
  logic                    bad;
  logic                    req_rdy;
  logic                    acc;
  logic                    acc_ld;
  logic                    rsp_pop;
  logic [CW-1:0]           credit;

  logic                    mem_ce_p0;
  logic                    mem_we_p0;
  logic [MAW-1:0]          mem_addr_p0;
  logic [RW-1:0]           mem_wdata_p0;
  logic                    store_err_p0;
  tag_t                    tag_pipe [RD_LAT+1];

  tag_t                    tag_exit;
  logic [RW-1:0]           rdata_exit;
  logic                    fifo_push;
  logic [RW:0]             fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign row_full = bus.i_req_addr >> OB;
  assign row      = row_full[MAW-1:0];
  assign bad      = (bus.i_req_addr[OB-1:0] != '0) ||
                    (row_full >= SCALAR_WIDTH'(MEM_DEPTH));

  // Every load, good or bad, reserves a FIFO slot; stores never return data.
  assign req_rdy = !rst && (credit != '0);
  assign acc     = bus.i_req_vld && req_rdy;
  assign acc_ld  = acc && !bus.i_req_we;
  assign rsp_pop = !fifo_empty && bus.i_rsp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CW'(RSP_DEPTH);
    end else begin
      case ({acc_ld, rsp_pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // Stage p0: SRAM issue and tag entry, one cycle after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_p0    <= 1'b0;
      mem_we_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      store_err_p0 <= 1'b0;
      for (int k = 0; k <= RD_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      mem_ce_p0    <= acc && !bad;
      mem_we_p0    <= acc && bus.i_req_we && !bad;
      mem_addr_p0  <= (acc && !bad) ? row : '0;
      mem_wdata_p0 <= (acc && bus.i_req_we && !bad) ? bus.i_req_wdata : '0;
      store_err_p0 <= acc && bus.i_req_we && bad;
      tag_pipe[0]  <= tag_t'{vld: acc_ld, err: acc_ld && bad};
      for (int k = 1; k <= RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Tag exit lines up with SRAM read data; rejected loads return zero data
  assign tag_exit   = tag_pipe[RD_LAT];
  assign fifo_push  = tag_exit.vld;
  assign rdata_exit = tag_exit.err ? '0 : bus.i_mem_rdata;

  vmu_rsp_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({rdata_exit, tag_exit.err}),
    .pop       (rsp_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !rsp_pop))
    else $error("vmu_mem_resp: response FIFO overflow");

  assign bus.o_req_rdy   = req_rdy;
  assign bus.o_mem_ce    = mem_ce_p0;
  assign bus.o_mem_we    = mem_we_p0;
  assign bus.o_mem_addr  = mem_addr_p0;
  assign bus.o_mem_wdata = mem_wdata_p0;
  assign bus.o_store_err = store_err_p0;
  assign bus.o_rsp_vld   = !fifo_empty;
  assign bus.o_rsp_data  = fifo_head[RW:1];
  assign bus.o_rsp_err   = fifo_head[0];
  assign bus.o_busy      = (credit != CW'(RSP_DEPTH));

endmodule
